hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: the pipeline side (drives hazard inputs, consumes controls).
// slave: the hazard controller itself.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    // Hazard sources from the pipeline
    logic             ID_EX_MemRead_i;
    logic [4:0]       ID_EX_RD_i;
    logic [4:0]       IF_ID_RS1_i;
    logic [4:0]       IF_ID_RS2_i;
    logic             IF_ID_UsesRS2_i;
    logic             EX_BranchTaken_i;
    logic             MEM_Req_i;
    logic             MEM_Ready_i;

    // Pipeline controls and status
    logic             PC_Write_o;
    logic             IF_ID_Write_o;
    logic             IF_ID_Flush_o;
    logic             ID_EX_Flush_o;
    logic             EX_MEM_Write_o;
    logic             MEM_WB_Bubble_o;
    logic [1:0]       State_o;
    logic             MemTimeout_o;
    logic [CNT_W-1:0] StallCnt_o;
    logic [CNT_W-1:0] FlushCnt_o;

    modport master (
        output ID_EX_MemRead_i, ID_EX_RD_i, IF_ID_RS1_i, IF_ID_RS2_i, IF_ID_UsesRS2_i,
        output EX_BranchTaken_i, MEM_Req_i, MEM_Ready_i,
        input  PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Write_o,
        input  MEM_WB_Bubble_o, State_o, MemTimeout_o, StallCnt_o, FlushCnt_o
    );

    modport slave (
        input  ID_EX_MemRead_i, ID_EX_RD_i, IF_ID_RS1_i, IF_ID_RS2_i, IF_ID_UsesRS2_i,
        input  EX_BranchTaken_i, MEM_Req_i, MEM_Ready_i,
        output PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Write_o,
        output MEM_WB_Bubble_o, State_o, MemTimeout_o, StallCnt_o, FlushCnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, memory wait
// stalls with a timeout into a sticky error state, plus saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input logic          clk_i,
    input logic          rst_n_i,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StError   = 2'b10
    } state_e;

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use, mem_stall;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble;

    // Hazard terms; x0 is never a real producer so it cannot cause a stall.
    always_comb begin
        load_use  = bus.ID_EX_MemRead_i && (bus.ID_EX_RD_i != 5'd0) &&
                    ((bus.ID_EX_RD_i == bus.IF_ID_RS1_i) ||
                     (bus.IF_ID_UsesRS2_i && (bus.ID_EX_RD_i == bus.IF_ID_RS2_i)));
        mem_stall = bus.MEM_Req_i && !bus.MEM_Ready_i;
    end

    // Next-state, wait counter and pipeline controls.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    state_d       = StMemWait;
                    wait_cnt_d    = 8'd1;
                end else if (bus.EX_BranchTaken_i) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            StMemWait: begin
                // On the Ready cycle the defaults let EX/MEM and MEM/WB take the access.
                if (bus.MEM_Ready_i) begin
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    if (wait_cnt_q >= TimeoutVal) begin
                        state_d = StError;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            StError: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (if_id_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Drive the bundle.
    always_comb begin
        bus.PC_Write_o      = pc_write;
        bus.IF_ID_Write_o   = if_id_write;
        bus.IF_ID_Flush_o   = if_id_flush;
        bus.ID_EX_Flush_o   = id_ex_flush;
        bus.EX_MEM_Write_o  = ex_mem_write;
        bus.MEM_WB_Bubble_o = mem_wb_bubble;
        bus.State_o         = state_q;
        bus.MemTimeout_o    = (state_q == StError);
        bus.StallCnt_o      = stall_cnt_q;
        bus.FlushCnt_o      = flush_cnt_q;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random stimulus against a reference model.
module tb_hazard_ctrl;
    localparam int unsigned Timeout = 4;
    localparam int unsigned CntW    = 4;
    localparam int          CntMax  = 15;

    logic clk;
    logic rst_n;

    hazard_ctrl_if #(.CNT_W(CntW)) hif ();

    hazard_ctrl #(
        .TIMEOUT_CYCLES(Timeout),
        .CNT_W         (CntW)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: error latched, waiting on memory, length of current wait.
    bit m_err;
    bit m_wait;
    int m_waited;
    int m_stall;
    int m_flush;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Controls {pc_w, ifid_w, ifid_flush, idex_flush, exmem_w, bubble, timeout}.
    function automatic logic [6:0] model_ctl(input bit mr, input bit [4:0] rd, input bit [4:0] rs1,
                                             input bit [4:0] rs2, input bit u2, input bit br,
                                             input bit req, input bit rdy);
        bit lu;
        lu = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
        if (m_err)               return 7'b0000011;
        if (m_wait)              return rdy ? 7'b1100100 : 7'b0000010;
        if (req && !rdy)         return 7'b0000010;
        if (br)                  return 7'b1111100;
        if (lu)                  return 7'b0001100;
        return 7'b1100100;
    endfunction

    function automatic int exp_state();
        return m_err ? 2 : (m_wait ? 1 : 0);
    endfunction

    function automatic logic [6:0] got_ctl();
        return {hif.PC_Write_o, hif.IF_ID_Write_o, hif.IF_ID_Flush_o, hif.ID_EX_Flush_o,
                hif.EX_MEM_Write_o, hif.MEM_WB_Bubble_o, hif.MemTimeout_o};
    endfunction

    task automatic set_inputs(input bit mr, input bit [4:0] rd, input bit [4:0] rs1,
                              input bit [4:0] rs2, input bit u2, input bit br,
                              input bit req, input bit rdy);
        hif.ID_EX_MemRead_i  = mr;
        hif.ID_EX_RD_i       = rd;
        hif.IF_ID_RS1_i      = rs1;
        hif.IF_ID_RS2_i      = rs2;
        hif.IF_ID_UsesRS2_i  = u2;
        hif.EX_BranchTaken_i = br;
        hif.MEM_Req_i        = req;
        hif.MEM_Ready_i      = rdy;
    endtask

    // One clock cycle: check registered state, apply inputs, check controls, advance model.
    task automatic step(input bit mr, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit u2, input bit br, input bit req, input bit rdy);
        logic [6:0] ctl;
        @(negedge clk);
        check_eq("state", 32'(hif.State_o), exp_state());
        check_eq("stall_cnt", 32'(hif.StallCnt_o), m_stall);
        check_eq("flush_cnt", 32'(hif.FlushCnt_o), m_flush);
        set_inputs(mr, rd, rs1, rs2, u2, br, req, rdy);
        #1;
        ctl = model_ctl(mr, rd, rs1, rs2, u2, br, req, rdy);
        check_eq("controls", 32'(got_ctl()), 32'(ctl));
        @(posedge clk);
        if (!ctl[6] && m_stall < CntMax) m_stall++;
        if (ctl[4] && m_flush < CntMax) m_flush++;
        if (!m_err) begin
            if (m_wait) begin
                if (rdy) m_wait = 0;
                else if (m_waited >= Timeout) begin
                    m_err  = 1;
                    m_wait = 0;
                end else m_waited++;
            end else if (req && !rdy) begin
                m_wait   = 1;
                m_waited = 1;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset dropped mid-cycle; effect must be visible before the next clock edge.
    task automatic do_reset();
        @(negedge clk);
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_state", 32'(hif.State_o), 0);
        check_eq("rst_pc_write", 32'(hif.PC_Write_o), 1);
        check_eq("rst_timeout", 32'(hif.MemTimeout_o), 0);
        check_eq("rst_stall_cnt", 32'(hif.StallCnt_o), 0);
        check_eq("rst_flush_cnt", 32'(hif.FlushCnt_o), 0);
        m_err = 0; m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        m_err = 0; m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Load-use on RS1, then x0 destination causes nothing.
        step(1, 5, 5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        #1 check_eq("lu_stall_cnt", 32'(hif.StallCnt_o), 1);
        step(1, 7, 1, 7, 1, 0, 0, 0);
        step(1, 7, 1, 7, 0, 0, 0, 0);

        // Branch together with load-use: branch wins.
        do_reset();
        step(1, 5, 5, 0, 0, 1, 0, 0);
        idle();
        #1;
        check_eq("br_lu_flush_cnt", 32'(hif.FlushCnt_o), 1);
        check_eq("br_lu_stall_cnt", 32'(hif.StallCnt_o), 0);

        // Memory wait of three cycles with a branch pending.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        #1 check_eq("mw_state_c2", 32'(hif.State_o), 1);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        #1 check_eq("mw_state_c3", 32'(hif.State_o), 1);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        #1;
        check_eq("mw_state_exit", 32'(hif.State_o), 0);
        check_eq("mw_stall_cnt", 32'(hif.StallCnt_o), 3);
        check_eq("mw_no_flush", 32'(hif.FlushCnt_o), 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        #1 check_eq("mw_branch_after", 32'(hif.FlushCnt_o), 1);

        // Timeout into the sticky error state.
        do_reset();
        repeat (5) step(0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        check_eq("to_state", 32'(hif.State_o), 2);
        check_eq("to_flag", 32'(hif.MemTimeout_o), 1);
        repeat (2) step(0, 0, 0, 0, 0, 1, 1, 1);
        #1 check_eq("to_sticky", 32'(hif.State_o), 2);
        do_reset();

        // Asynchronous reset in the middle of a memory wait.
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        #1 check_eq("pre_rst_state", 32'(hif.State_o), 1);
        do_reset();

        // Stall counter saturation.
        repeat (20) step(1, 5, 5, 0, 0, 0, 0, 0);
        #1 check_eq("sat_stall_cnt", 32'(hif.StallCnt_o), CntMax);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            else step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
